// File: rtl/concat_load_ctrl.sv
// rtl/concat_load_ctrl.sv - Concatenator buffer load sequencer
// Clears the buffer, streams bytes in, zero-pads to a 64-byte boundary and hands the block off.
module concat_load_ctrl #(
   parameter  int DATA_SIZE    = 8,
   parameter  int NUM_MATRICES = 20,
   localparam int NO_REG       = 64 * NUM_MATRICES,
   localparam int AW           = $clog2(NO_REG),
   localparam int LW           = $clog2(NO_REG + 1)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_SIZE-1:0] in_data,
   input  logic                 in_valid,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic [DATA_SIZE-1:0] cat_data,
   output logic                 cat_we,
   output logic [AW-1:0]        cat_addr,
   output logic                 cat_clr,
   input  logic                 cat_full,
   output logic                 blk_valid,
   output logic [LW-1:0]        blk_len,
   input  logic                 blk_ready,
   output logic [15:0]          blk_count,
   output logic                 err
);

   typedef enum logic [2:0] {
      S_CLEAR,
      S_FILL,
      S_PAD,
      S_FLUSH,
      S_HANDOFF
   } state_t;

   state_t               state, state_nx;
   logic [LW-1:0]        count, count_nx, count_inc;
   logic                 wr_en;
   logic [DATA_SIZE-1:0] wr_data;
   logic                 len_ld;

   assign count_inc = count + LW'(1);

   assign in_ready  = (state == S_FILL);
   assign cat_clr   = (state == S_CLEAR);
   assign blk_valid = (state == S_HANDOFF);

   always_comb begin
      state_nx = state;
      count_nx = count;
      wr_en    = 1'b0;
      wr_data  = '0;
      len_ld   = 1'b0;
      case (state)
         S_CLEAR: begin
            count_nx = '0;
            state_nx = S_FILL;
         end
         S_FILL: begin
            if (in_valid) begin
               wr_en    = 1'b1;
               wr_data  = in_data;
               len_ld   = 1'b1;
               count_nx = count_inc;
               // A full buffer ends the block even without in_last.
               if (count_inc == LW'(NO_REG))
                  state_nx = S_FLUSH;
               else if (in_last)
                  state_nx = (count_inc[5:0] != 6'd0) ? S_PAD : S_FLUSH;
            end
         end
         S_PAD: begin
            wr_en    = 1'b1;
            count_nx = count_inc;
            if (count_inc[5:0] == 6'd0)
               state_nx = S_FLUSH;
         end
         S_FLUSH: begin
            state_nx = S_HANDOFF;
         end
         S_HANDOFF: begin
            if (blk_ready)
               state_nx = S_CLEAR;
         end
         default: state_nx = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_CLEAR;
         count     <= '0;
         cat_we    <= 1'b0;
         cat_data  <= '0;
         cat_addr  <= '0;
         blk_len   <= '0;
         blk_count <= '0;
         err       <= 1'b0;
      end else begin
         state  <= state_nx;
         count  <= count_nx;
         cat_we <= wr_en;
         if (wr_en) begin
            cat_data <= wr_data;
            cat_addr <= count[AW-1:0];
         end
         if (len_ld)
            blk_len <= count_inc;
         if (state == S_HANDOFF && blk_ready)
            blk_count <= blk_count + 16'd1;
         if (cat_full && (state == S_FILL || state == S_PAD))
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_concat_load_ctrl.sv
// tb/tb_concat_load_ctrl.sv - randomized bench for concat_load_ctrl
// Message-level model predicts writes, block lengths, handshakes and err each cycle.
module tb_concat_load_ctrl;

   localparam int NO_REG = 1280;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_last = 1'b0;
   logic        in_ready;
   logic [7:0]  cat_data;
   logic        cat_we;
   logic [10:0] cat_addr;
   logic        cat_clr;
   logic        cat_full = 1'b0;
   logic        blk_valid;
   logic [10:0] blk_len;
   logic        blk_ready = 1'b0;
   logic [15:0] blk_count;
   logic        err;

   concat_load_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .cat_data  (cat_data),
      .cat_we    (cat_we),
      .cat_addr  (cat_addr),
      .cat_clr   (cat_clr),
      .cat_full  (cat_full),
      .blk_valid (blk_valid),
      .blk_len   (blk_len),
      .blk_ready (blk_ready),
      .blk_count (blk_count),
      .err       (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
      end
   endtask

   // Reference model: expected writes and blocks derived from the accepted bytes.
   typedef struct { int addr; int data; } wr_t;
   typedef struct { int len; int nw; } blk_t;
   wr_t  wq[$];
   blk_t bq[$];
   wr_t  w;
   int   m_count, popped, pad_left, exp_blk_count, pcount;
   bit   busy, in_handoff, clear_now, exp_err, cur_clear, exp_rdy;
   int   obs_writes, last_addr, snap_writes, snap_len, snap_last_addr;
   bit   prev_bv;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_cat_clr", cat_clr, 1);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_blk_valid", blk_valid, 0);
         chk("rst_cat_we", cat_we, 0);
         chk("rst_cat_data", cat_data, 0);
         chk("rst_cat_addr", cat_addr, 0);
         chk("rst_blk_len", blk_len, 0);
         chk("rst_blk_count", blk_count, 0);
         chk("rst_err", err, 0);
         wq.delete();
         bq.delete();
         m_count = 0; popped = 0; pad_left = 0; exp_blk_count = 0;
         busy = 0; in_handoff = 0; clear_now = 1; exp_err = 0;
         obs_writes = 0; prev_bv = 0;
      end else begin
         cur_clear = clear_now;
         clear_now = 0;
         exp_rdy   = !busy && !cur_clear;
         chk("in_ready", in_ready, exp_rdy);
         chk("cat_clr", cat_clr, cur_clear);
         chk("blk_valid", blk_valid, in_handoff);
         chk("err", err, exp_err);
         chk("blk_count", blk_count, exp_blk_count & 32'hFFFF);
         if (in_handoff && bq.size() > 0) begin
            chk("blk_len", blk_len, bq[0].len);
            if (blk_ready) begin
               exp_blk_count++;
               in_handoff = 0;
               busy = 0;
               clear_now = 1;
               void'(bq.pop_front());
               popped = 0;
            end
         end
         chk("cat_we", cat_we, wq.size() > 0);
         if (cat_we && wq.size() > 0) begin
            w = wq.pop_front();
            chk("cat_addr", cat_addr, w.addr);
            chk("cat_data", cat_data, w.data);
            popped++;
            if (bq.size() > 0 && popped == bq[0].nw) in_handoff = 1;
         end
         if (cat_full && (exp_rdy || pad_left > 0)) exp_err = 1;
         if (pad_left > 0) pad_left--;
         if (exp_rdy && in_valid) begin
            wq.push_back('{m_count, int'(in_data)});
            m_count++;
            if (m_count == NO_REG || in_last) begin
               pcount = (64 - (m_count % 64)) % 64;
               for (int i = 0; i < pcount; i++) wq.push_back('{m_count + i, 0});
               pad_left = pcount;
               bq.push_back('{m_count, m_count + pcount});
               busy = 1;
               m_count = 0;
            end
         end
         if (cat_clr) obs_writes = 0;
         if (cat_we) begin
            obs_writes++;
            last_addr = int'(cat_addr);
         end
         if (blk_valid && !prev_bv) begin
            snap_writes    = obs_writes;
            snap_len       = int'(blk_len);
            snap_last_addr = last_addr;
         end
         prev_bv = blk_valid;
      end
   end

   // Consumer: holds blk_ready low for hold cycles of HANDOFF, random noise elsewhere.
   int hold_target = -1;
   int hc = 0;
   int tgt = 0;
   initial forever begin
      @(posedge clk);
      #1;
      if (blk_valid) begin
         if (hc == 0) tgt = (hold_target >= 0) ? hold_target : int'($urandom_range(0, 3));
         blk_ready = (hc >= tgt);
         hc++;
      end else begin
         hc = 0;
         blk_ready = ($urandom % 4 == 0);
      end
   end

   task automatic send_byte(input logic [7:0] d, input bit last, input int idle);
      int t;
      for (int i = 0; i < idle; i++) begin
         in_valid = 1'b0;
         @(posedge clk);
         #1;
      end
      in_data  = d;
      in_last  = last;
      in_valid = 1'b1;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!in_ready && t < 4000);
      if (!in_ready) begin
         n_cmp++;
         n_bad++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 at %0t", $time);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_msg(input int len, input bit last, input bit rnd, input int idle_pct);
      logic [7:0] d;
      int idle;
      for (int i = 0; i < len; i++) begin
         d = rnd ? 8'($urandom) : 8'(i);
         idle = (int'($urandom % 100) < idle_pct) ? int'($urandom_range(1, 3)) : 0;
         send_byte(d, last && (i == len - 1), idle);
      end
   endtask

   task automatic wait_cleared();
      int t;
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!cat_clr && t < 5000);
      if (!cat_clr) begin
         n_cmp++;
         n_bad++;
         $display("FAIL clear_timeout: got cat_clr 0 expected 1 at %0t", $time);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish at %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1);
   end

   int nblk;
   int len;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("first_clear_clr", cat_clr, 1);
      chk("first_clear_rdy", in_ready, 0);
      @(negedge clk);
      chk("first_fill_rdy", in_ready, 1);
      @(posedge clk);
      #1;

      // Full block, sequential data, no in_last; Concatenator reports full afterwards.
      hold_target = 3;
      send_msg(NO_REG, 0, 0, 0);
      cat_full = 1'b1;
      wait_cleared();
      cat_full = 1'b0;
      chk("full_len", snap_len, 1280);
      chk("full_writes", snap_writes, 1280);
      chk("full_last_addr", snap_last_addr, 1279);
      chk("full_err", err, 0);
      chk("full_count", blk_count, 1);

      // Short message padded to 128.
      hold_target = 0;
      send_msg(70, 1, 1, 0);
      wait_cleared();
      chk("short_len", snap_len, 70);
      chk("short_writes", snap_writes, 128);
      chk("short_last_addr", snap_last_addr, 127);

      // Aligned last byte: no padding.
      send_msg(64, 1, 1, 0);
      wait_cleared();
      chk("aligned_len", snap_len, 64);
      chk("aligned_writes", snap_writes, 64);

      // Backpressure: next message pending with in_valid high through HANDOFF.
      hold_target = 10;
      send_msg(5, 1, 1, 0);
      send_msg(3, 1, 1, 0);
      wait_cleared();
      chk("bp_count", blk_count, 5);
      chk("bp_len", snap_len, 3);
      hold_target = -1;

      nblk = 5;
      for (int m = 0; m < 25; m++) begin
         len = ($urandom % 8 == 0) ? int'($urandom_range(1, NO_REG)) : int'($urandom_range(1, 200));
         send_msg(len, 1, 1, 20);
         nblk++;
      end
      wait_cleared();
      chk("rand_count", blk_count, nblk);

      // Reset in the middle of PAD.
      send_msg(10, 1, 1, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Concatenator full mid-fill sets sticky err; reset clears it.
      send_msg(299, 0, 1, 0);
      cat_full = 1'b1;
      send_msg(20, 0, 1, 0);
      chk("fault_err", err, 1);
      repeat (5) @(posedge clk);
      #1;
      chk("fault_err_sticky", err, 1);
      rst = 1'b1;
      cat_full = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_err", err, 0);
      chk("post_rst_count", blk_count, 0);
      @(posedge clk);
      #1;
      send_msg(40, 1, 1, 0);
      wait_cleared();
      chk("post_rst_len", snap_len, 40);
      chk("post_rst_writes", snap_writes, 64);
      chk("post_rst_blk", blk_count, 1);

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
